// File: rtl/lc3_unified_mem.sv
// Unified LC3 instruction/data memory with programmable access latency.
// One access in flight at a time; data requests take priority over fetches.
module lc3_unified_mem #(
  parameter int AW  = 12,
  parameter int LAT = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        instrmem_rd,
  input  logic [15:0] pc,
  output logic [15:0] Instr_dout,
  output logic        complete_instr,
  input  logic        Data_req,
  input  logic        Data_rd,
  input  logic [15:0] Data_addr,
  input  logic [15:0] Data_din,
  output logic [15:0] Data_dout,
  output logic        complete_data,
  input  logic        load_en,
  input  logic [15:0] load_addr,
  input  logic [15:0] load_data,
  output logic [1:0]  fsm_state
);

  generate
    if (LAT < 1 || LAT > 15) begin : g_lat_check
      $error("lc3_unified_mem: LAT must be within 1..15");
    end
    if (AW < 1 || AW > 15) begin : g_aw_check
      $error("lc3_unified_mem: AW must be within 1..15");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t        state;
  state_t        state_next;
  logic [3:0]    cnt;
  logic [AW-1:0] addr_q;
  logic          rd_q;
  logic          is_data_q;
  logic [15:0]   din_q;
  logic          take_data;
  logic          take_instr;
  logic          finish;
  logic          store_commit;
  logic [AW-1:0] load_idx;
  logic [15:0]   mem [0:(1<<AW)-1];

  // Upper address bits alias onto the array and are deliberately ignored.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{pc[15:AW], Data_addr[15:AW], load_addr[15:AW]};

  assign fsm_state = state;
  assign load_idx  = load_addr[AW-1:0];

  always_comb begin
    state_next = state;
    take_data  = 1'b0;
    take_instr = 1'b0;
    finish     = 1'b0;
    case (state)
      IDLE: begin
        if (Data_req) begin
          take_data  = 1'b1;
          state_next = WAIT;
        end else if (instrmem_rd) begin
          take_instr = 1'b1;
          state_next = WAIT;
        end
      end
      WAIT: begin
        if (cnt == 4'd0) begin
          finish     = 1'b1;
          state_next = RESP;
        end
      end
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // A store aborted by reset must leave memory untouched.
  assign store_commit = finish && is_data_q && !rd_q && !reset;

  always_ff @(posedge clock) begin
    if (reset) begin
      state          <= IDLE;
      cnt            <= 4'd0;
      complete_instr <= 1'b0;
      complete_data  <= 1'b0;
      Instr_dout     <= 16'h0000;
      Data_dout      <= 16'h0000;
      addr_q         <= '0;
      rd_q           <= 1'b0;
      is_data_q      <= 1'b0;
      din_q          <= 16'h0000;
    end else begin
      state          <= state_next;
      complete_instr <= finish && !is_data_q;
      complete_data  <= finish && is_data_q;
      if (take_data) begin
        addr_q    <= Data_addr[AW-1:0];
        rd_q      <= Data_rd;
        din_q     <= Data_din;
        is_data_q <= 1'b1;
        cnt       <= 4'(LAT - 1);
      end else if (take_instr) begin
        addr_q    <= pc[AW-1:0];
        rd_q      <= 1'b1;
        is_data_q <= 1'b0;
        cnt       <= 4'(LAT - 1);
      end else if (state == WAIT && cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end
      if (finish) begin
        if (!is_data_q) begin
          Instr_dout <= mem[addr_q];
        end else if (rd_q) begin
          Data_dout <= mem[addr_q];
        end
      end
    end
  end

  // Backdoor writes run in every state; a same-index store commit overrides them.
  always_ff @(posedge clock) begin
    if (load_en && !(store_commit && (load_idx == addr_q))) begin
      mem[load_idx] <= load_data;
    end
    if (store_commit) begin
      mem[addr_q] <= din_q;
    end
  end

endmodule

// File: tb/tb_lc3_unified_mem.sv
// Directed bench for lc3_unified_mem at LAT=1, 2 and 3 with an expected-data queue.
module tb_lc3_unified_mem;

  logic        clock;
  logic        reset;
  logic        instrmem_rd;
  logic [15:0] pc;
  logic        Data_req;
  logic        Data_rd;
  logic [15:0] Data_addr;
  logic [15:0] Data_din;
  logic        load_en;
  logic [15:0] load_addr;
  logic [15:0] load_data;

  logic [15:0] idout_l1, idout_l2, idout_l3;
  logic [15:0] ddout_l1, ddout_l2, ddout_l3;
  logic        ci_l1, ci_l2, ci_l3;
  logic        cd_l1, cd_l2, cd_l3;
  logic [1:0]  st_l1, st_l2, st_l3;

  // outputs of the instance currently under test
  int          sel;
  logic [15:0] idout, ddout;
  logic        ci, cd;
  logic [1:0]  st;

  int vectors;
  int errors;
  logic [15:0] exp_q[$];

  int n, nd, ni, t0, t1, k;
  bit seen, got_i;

  lc3_unified_mem #(.AW(12), .LAT(1)) u_lat1 (
    .clock(clock), .reset(reset), .instrmem_rd(instrmem_rd), .pc(pc),
    .Instr_dout(idout_l1), .complete_instr(ci_l1), .Data_req(Data_req),
    .Data_rd(Data_rd), .Data_addr(Data_addr), .Data_din(Data_din),
    .Data_dout(ddout_l1), .complete_data(cd_l1), .load_en(load_en),
    .load_addr(load_addr), .load_data(load_data), .fsm_state(st_l1)
  );

  lc3_unified_mem #(.AW(12), .LAT(2)) u_lat2 (
    .clock(clock), .reset(reset), .instrmem_rd(instrmem_rd), .pc(pc),
    .Instr_dout(idout_l2), .complete_instr(ci_l2), .Data_req(Data_req),
    .Data_rd(Data_rd), .Data_addr(Data_addr), .Data_din(Data_din),
    .Data_dout(ddout_l2), .complete_data(cd_l2), .load_en(load_en),
    .load_addr(load_addr), .load_data(load_data), .fsm_state(st_l2)
  );

  lc3_unified_mem #(.AW(12), .LAT(3)) u_lat3 (
    .clock(clock), .reset(reset), .instrmem_rd(instrmem_rd), .pc(pc),
    .Instr_dout(idout_l3), .complete_instr(ci_l3), .Data_req(Data_req),
    .Data_rd(Data_rd), .Data_addr(Data_addr), .Data_din(Data_din),
    .Data_dout(ddout_l3), .complete_data(cd_l3), .load_en(load_en),
    .load_addr(load_addr), .load_data(load_data), .fsm_state(st_l3)
  );

  always_comb begin
    idout = idout_l2;
    ddout = ddout_l2;
    ci    = ci_l2;
    cd    = cd_l2;
    st    = st_l2;
    if (sel == 1) begin
      idout = idout_l1; ddout = ddout_l1; ci = ci_l1; cd = cd_l1; st = st_l1;
    end else if (sel == 3) begin
      idout = idout_l3; ddout = ddout_l3; ci = ci_l3; cd = cd_l3; st = st_l3;
    end
  end

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    reset       = 1'b1;
    instrmem_rd = 1'b0;
    Data_req    = 1'b0;
    load_en     = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic bd_write(input logic [15:0] addr, input logic [15:0] data);
    load_en   = 1'b1;
    load_addr = addr;
    load_data = data;
    @(negedge clock);
    load_en = 1'b0;
  endtask

  // One access; completion is expected at the (lat+1)th negedge after driving.
  // bd_at > 0 fires a backdoor write on the edge lat-relative index bd_at.
  task automatic access(input int lat, input bit is_data, input bit rd,
                        input logic [15:0] addr, input logic [15:0] din,
                        input logic [15:0] exp_val, input int bd_at,
                        input logic [15:0] bd_addr, input logic [15:0] bd_data,
                        input string tag);
    int  cnt;
    bit  done;
    logic [15:0] exp;
    sel = lat;
    exp_q.push_back(exp_val);
    if (is_data) begin
      Data_req = 1'b1; Data_rd = rd; Data_addr = addr; Data_din = din;
    end else begin
      instrmem_rd = 1'b1; pc = addr;
    end
    cnt  = 0;
    done = 1'b0;
    while (!done && cnt < 40) begin
      load_en   = (bd_at > 0) && (cnt == bd_at);
      load_addr = bd_addr;
      load_data = bd_data;
      @(negedge clock);
      cnt++;
      if (ci || cd) check({tag, "_overlap"}, {31'd0, ci && cd}, 32'd0);
      done = is_data ? cd : ci;
    end
    load_en     = 1'b0;
    Data_req    = 1'b0;
    instrmem_rd = 1'b0;
    check({tag, "_done"}, {31'd0, done}, 32'd1);
    if (done) begin
      check({tag, "_lat"}, cnt, lat + 1);
      exp = exp_q.pop_front();
      check({tag, "_data"}, is_data ? ddout : idout, exp);
      @(negedge clock);
      check({tag, "_pulse"}, {31'd0, is_data ? cd : ci}, 32'd0);
    end else begin
      exp_q.delete();
    end
  endtask

  initial begin
    vectors = 0;
    errors  = 0;
    sel     = 2;
    pc = 16'h0; Data_rd = 1'b0; Data_addr = 16'h0; Data_din = 16'h0;
    load_addr = 16'h0; load_data = 16'h0;

    // ---------------- LAT = 2 ----------------
    do_reset();
    sel = 2;
    check("rst_instr_dout", idout, 16'h0000);
    check("rst_data_dout", ddout, 16'h0000);
    check("rst_complete_instr", {31'd0, ci}, 32'd0);
    check("rst_complete_data", {31'd0, cd}, 32'd0);
    check("rst_state", st, 2'd0);

    bd_write(16'h3000, 16'h1261);
    bd_write(16'h3001, 16'h14A2);
    bd_write(16'h4100, 16'h0001);

    access(2, 1'b0, 1'b1, 16'h3000, 16'h0, 16'h1261, 0, 16'h0, 16'h0, "fetch");
    access(2, 1'b1, 1'b0, 16'h4005, 16'hBEEF, 16'h0000, 0, 16'h0, 16'h0, "store");
    access(2, 1'b1, 1'b1, 16'h4005, 16'h0, 16'hBEEF, 0, 16'h0, 16'h0, "load");

    // simultaneous data load and fetch
    exp_q.push_back(16'hBEEF);
    exp_q.push_back(16'h1261);
    Data_req = 1'b1; Data_rd = 1'b1; Data_addr = 16'h4005;
    instrmem_rd = 1'b1; pc = 16'h3000;
    n = 0; nd = -1; ni = -1; got_i = 1'b0;
    while (!got_i && n < 40) begin
      @(negedge clock);
      n++;
      if (ci || cd) check("sim_overlap", {31'd0, ci && cd}, 32'd0);
      if (cd) begin
        nd = n;
        Data_req = 1'b0;
        check("sim_d_data", ddout, exp_q.pop_front());
      end
      if (ci) begin
        ni = n;
        got_i = 1'b1;
        check("sim_i_data", idout, exp_q.pop_front());
      end
    end
    instrmem_rd = 1'b0;
    Data_req    = 1'b0;
    exp_q.delete();
    check("sim_d_lat", nd, 3);
    check("sim_i_lat", ni, 7);
    @(negedge clock);

    access(2, 1'b1, 1'b0, 16'h1234, 16'h00AA, 16'hBEEF, 0, 16'h0, 16'h0, "alias_st");
    access(2, 1'b1, 1'b1, 16'h5234, 16'h0, 16'h00AA, 0, 16'h0, 16'h0, "alias_ld");
    access(2, 1'b1, 1'b1, 16'h4100, 16'h0, 16'h7777, 1, 16'h4100, 16'h7777, "bd_pend");
    access(2, 1'b1, 1'b0, 16'h4300, 16'h3333, 16'h7777, 2, 16'h4300, 16'h4444, "collide_st");
    access(2, 1'b1, 1'b1, 16'h4300, 16'h0, 16'h3333, 0, 16'h0, 16'h0, "collide_ld");

    // ---------------- LAT = 1 ----------------
    do_reset();
    bd_write(16'h3000, 16'h1261);
    bd_write(16'h3001, 16'h14A2);
    sel = 1;
    exp_q.push_back(16'h1261);
    exp_q.push_back(16'h14A2);
    instrmem_rd = 1'b1; pc = 16'h3000;
    n = 0; k = 0; t0 = -1; t1 = -1;
    while (k < 2 && n < 40) begin
      @(negedge clock);
      n++;
      if (ci) begin
        if (k == 0) t0 = n; else t1 = n;
        check("b2b_data", idout, exp_q.pop_front());
        k++;
        pc = 16'h3001;
      end
    end
    instrmem_rd = 1'b0;
    exp_q.delete();
    check("b2b_first_lat", t0, 2);
    check("b2b_second_lat", t1, 5);
    @(negedge clock);

    // ---------------- LAT = 3 ----------------
    // backdoor write while reset is held
    reset = 1'b1;
    instrmem_rd = 1'b0;
    Data_req = 1'b0;
    bd_write(16'h4200, 16'h1111);
    @(negedge clock);
    reset = 1'b0;
    sel = 3;
    access(3, 1'b1, 1'b1, 16'h4200, 16'h0, 16'h1111, 0, 16'h0, 16'h0, "l3_load");
    access(3, 1'b0, 1'b1, 16'h3000, 16'h0, 16'h1261, 0, 16'h0, 16'h0, "l3_fetch");

    Data_req = 1'b1; Data_rd = 1'b0; Data_addr = 16'h4200; Data_din = 16'h2222;
    @(negedge clock);
    reset = 1'b1;
    Data_req = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    seen = 1'b0;
    repeat (6) begin
      @(negedge clock);
      if (cd) seen = 1'b1;
    end
    check("abort_no_complete", {31'd0, seen}, 32'd0);
    check("abort_data_dout", ddout, 16'h0000);
    check("abort_instr_dout", idout, 16'h0000);
    check("abort_state", st, 2'd0);
    access(3, 1'b1, 1'b1, 16'h4200, 16'h0, 16'h1111, 0, 16'h0, 16'h0, "abort_reload");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
